// File: rtl/sample_player.sv
// Streams one stored sample from a synchronous ROM at a fixed audio tick rate.
// A rising edge on s_reset (re)starts playback; s_EN pauses it.
module sample_player #(
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 8,
  parameter int SAMPLE_LEN = 12000,
  parameter int CLK_DIV    = 6250
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     s_EN,
  input  logic                     s_reset,
  input  logic signed [DATA_W-1:0] rom_data,
  output logic        [ADDR_W-1:0] rom_addr,
  output logic signed [DATA_W-1:0] sample_out,
  output logic                     sample_valid,
  output logic                     playing,
  output logic                     done
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PLAY  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [CNT_W-1:0]  DIV_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(SAMPLE_LEN - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] div_cnt;
  logic             s_reset_q;
  logic             restart;
  logic             div_run;
  logic             tick;

  assign restart = s_reset & ~s_reset_q;
  assign div_run = ((state == PLAY) && s_EN) || (state == DRAIN);
  assign tick    = div_run && (div_cnt == DIV_LAST);
  assign playing = (state == PLAY) || (state == DRAIN);
  assign done    = (state == DONE);

  // Restart wins over a coincident tick; a paused PLAY freezes divider, address and output.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      div_cnt      <= '0;
      s_reset_q    <= 1'b0;
      rom_addr     <= '0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
    end else begin
      s_reset_q    <= s_reset;
      sample_valid <= 1'b0;
      if (restart) begin
        state      <= PLAY;
        div_cnt    <= '0;
        rom_addr   <= '0;
        sample_out <= '0;
      end else begin
        if (div_run) begin
          div_cnt <= tick ? '0 : div_cnt + CNT_W'(1);
        end
        if (tick) begin
          case (state)
            PLAY: begin
              sample_out   <= rom_data;
              sample_valid <= 1'b1;
              if (rom_addr == ADDR_LAST) begin
                state <= DRAIN;
              end else begin
                rom_addr <= rom_addr + ADDR_W'(1);
              end
            end
            DRAIN: begin
              sample_out   <= '0;
              sample_valid <= 1'b1;
              state        <= DONE;
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_sample_player.sv
// Directed bench for sample_player with CLK_DIV=4, SAMPLE_LEN=5 and a ROM
// returning 8'h10+addr one cycle after the address.
module tb_sample_player;

  logic               clock;
  logic               resetn;
  logic               s_EN;
  logic               s_reset;
  logic signed [7:0]  rom_data;
  logic [13:0]        rom_addr;
  logic signed [7:0]  sample_out;
  logic               sample_valid;
  logic               playing;
  logic               done;

  int errors = 0;
  int checks = 0;

  sample_player #(
    .ADDR_W(14), .DATA_W(8), .SAMPLE_LEN(5), .CLK_DIV(4)
  ) dut (
    .clock(clock), .resetn(resetn), .s_EN(s_EN), .s_reset(s_reset),
    .rom_data(rom_data), .rom_addr(rom_addr), .sample_out(sample_out),
    .sample_valid(sample_valid), .playing(playing), .done(done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) rom_data <= 8'h10 + rom_addr[7:0];

  // Steps n clock cycles, sampling at each falling edge.
  task automatic run_cycles(input int n, output int pulses, output logic [7:0] val, output int pos);
    pulses = 0;
    val = 8'hxx;
    pos = 0;
    for (int i = 1; i <= n; i++) begin
      @(posedge clock);
      @(negedge clock);
      if (sample_valid === 1'b1) begin
        pulses++;
        val = sample_out;
        pos = i;
      end
    end
  endtask

  task automatic restart_pulse();
    s_reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    s_reset = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0; s_EN = 1'b0; s_reset = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if ({rom_addr, sample_out, sample_valid, playing, done} !== 25'd0) begin
      errors++;
      $display("FAIL reset_outputs: addr=%0d out=%h vld=%b play=%b done=%b required all 0",
               rom_addr, sample_out, sample_valid, playing, done);
    end
    resetn = 1'b1;
  endtask

  task automatic test_basic();
    logic [7:0] exp [6] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h00};
    int p, pos;
    logic [7:0] v;
    s_EN = 1'b1;
    restart_pulse();
    checks++;
    if (playing !== 1'b1 || rom_addr !== 14'd0) begin
      errors++;
      $display("FAIL basic_start: playing=%b addr=%0d required 1/0", playing, rom_addr);
    end
    for (int k = 0; k < 6; k++) begin
      run_cycles(4, p, v, pos);
      checks++;
      if (p !== 1 || pos !== 4 || v !== exp[k]) begin
        errors++;
        $display("FAIL basic_sample%0d: pulses=%0d pos=%0d val=%h required 1/4/%h", k, p, pos, v, exp[k]);
      end
      checks++;
      if (playing !== (k < 5) || done !== (k == 5)) begin
        errors++;
        $display("FAIL basic_flags%0d: playing=%b done=%b required %b/%b", k, playing, done, k < 5, k == 5);
      end
    end
    run_cycles(8, p, v, pos);
    checks++;
    if (p !== 0 || done !== 1'b1 || sample_out !== 8'h00) begin
      errors++;
      $display("FAIL basic_idle_done: pulses=%0d done=%b out=%h required 0/1/00", p, done, sample_out);
    end
  endtask

  task automatic test_hold_reset();
    int p, pos;
    logic [7:0] v;
    s_reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    run_cycles(24, p, v, pos);
    checks++;
    if (p !== 6 || pos !== 24 || v !== 8'h00 || done !== 1'b1) begin
      errors++;
      $display("FAIL hold_playback: pulses=%0d pos=%0d last=%h done=%b required 6/24/00/1", p, pos, v, done);
    end
    run_cycles(5, p, v, pos);
    s_reset = 1'b0;
    checks++;
    if (p !== 0 || done !== 1'b1) begin
      errors++;
      $display("FAIL hold_no_retrigger: pulses=%0d done=%b required 0/1", p, done);
    end
    run_cycles(8, p, v, pos);
    checks++;
    if (p !== 0 || done !== 1'b1 || playing !== 1'b0) begin
      errors++;
      $display("FAIL hold_after_release: pulses=%0d done=%b playing=%b required 0/1/0", p, done, playing);
    end
  endtask

  task automatic test_pause();
    int p, pos;
    logic [7:0] v;
    restart_pulse();
    run_cycles(4, p, v, pos);
    run_cycles(4, p, v, pos);
    checks++;
    if (p !== 1 || pos !== 4 || v !== 8'h11) begin
      errors++;
      $display("FAIL pause_pre: pulses=%0d pos=%0d val=%h required 1/4/11", p, pos, v);
    end
    s_EN = 1'b0;
    run_cycles(10, p, v, pos);
    checks++;
    if (p !== 0 || sample_out !== 8'h11 || rom_addr !== 14'd2 || playing !== 1'b1) begin
      errors++;
      $display("FAIL pause_hold: pulses=%0d out=%h addr=%0d playing=%b required 0/11/2/1",
               p, sample_out, rom_addr, playing);
    end
    s_EN = 1'b1;
    run_cycles(4, p, v, pos);
    checks++;
    if (p !== 1 || pos !== 4 || v !== 8'h12) begin
      errors++;
      $display("FAIL pause_resume: pulses=%0d pos=%0d val=%h required 1/4/12", p, pos, v);
    end
    run_cycles(12, p, v, pos);
    checks++;
    if (p !== 3 || v !== 8'h00 || done !== 1'b1) begin
      errors++;
      $display("FAIL pause_finish: pulses=%0d last=%h done=%b required 3/00/1", p, v, done);
    end
  endtask

  task automatic test_restart_collision();
    int p, pos;
    logic [7:0] v;
    restart_pulse();
    run_cycles(12, p, v, pos);
    checks++;
    if (p !== 3 || v !== 8'h12) begin
      errors++;
      $display("FAIL coll_pre: pulses=%0d last=%h required 3/12", p, v);
    end
    run_cycles(3, p, v, pos);
    s_reset = 1'b1;
    run_cycles(1, p, v, pos);
    s_reset = 1'b0;
    checks++;
    if (p !== 0 || rom_addr !== 14'd0 || sample_out !== 8'h00 || playing !== 1'b1) begin
      errors++;
      $display("FAIL coll_restart: pulses=%0d addr=%0d out=%h playing=%b required 0/0/00/1",
               p, rom_addr, sample_out, playing);
    end
    run_cycles(4, p, v, pos);
    checks++;
    if (p !== 1 || pos !== 4 || v !== 8'h10) begin
      errors++;
      $display("FAIL coll_next: pulses=%0d pos=%0d val=%h required 1/4/10", p, pos, v);
    end
    run_cycles(20, p, v, pos);
    checks++;
    if (p !== 5 || v !== 8'h00 || done !== 1'b1) begin
      errors++;
      $display("FAIL coll_finish: pulses=%0d last=%h done=%b required 5/00/1", p, v, done);
    end
  endtask

  task automatic test_async_reset();
    int p, pos;
    logic [7:0] v;
    restart_pulse();
    run_cycles(13, p, v, pos);
    checks++;
    if (rom_addr !== 14'd3 || sample_out !== 8'h12) begin
      errors++;
      $display("FAIL areset_pre: addr=%0d out=%h required 3/12", rom_addr, sample_out);
    end
    #2 resetn = 1'b0;
    #1;
    checks++;
    if ({rom_addr, sample_out, sample_valid, playing, done} !== 25'd0) begin
      errors++;
      $display("FAIL areset_immediate: addr=%0d out=%h vld=%b play=%b done=%b required all 0",
               rom_addr, sample_out, sample_valid, playing, done);
    end
    @(negedge clock);
    resetn = 1'b1;
    run_cycles(12, p, v, pos);
    checks++;
    if (p !== 0 || playing !== 1'b0 || done !== 1'b0 || rom_addr !== 14'd0) begin
      errors++;
      $display("FAIL areset_idle: pulses=%0d playing=%b done=%b addr=%0d required 0/0/0/0",
               p, playing, done, rom_addr);
    end
  endtask

  task automatic test_replay_from_done();
    logic [7:0] exp [6] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h00};
    int p, pos;
    logic [7:0] v;
    restart_pulse();
    run_cycles(24, p, v, pos);
    checks++;
    if (p !== 6 || done !== 1'b1) begin
      errors++;
      $display("FAIL replay_first: pulses=%0d done=%b required 6/1", p, done);
    end
    restart_pulse();
    for (int k = 0; k < 6; k++) begin
      run_cycles(4, p, v, pos);
      checks++;
      if (p !== 1 || pos !== 4 || v !== exp[k]) begin
        errors++;
        $display("FAIL replay_sample%0d: pulses=%0d pos=%0d val=%h required 1/4/%h", k, p, pos, v, exp[k]);
      end
    end
    checks++;
    if (done !== 1'b1 || playing !== 1'b0) begin
      errors++;
      $display("FAIL replay_done: done=%b playing=%b required 1/0", done, playing);
    end
  endtask

  initial begin
    resetn = 1'b0;
    s_EN = 1'b0;
    s_reset = 1'b0;
    test_reset();
    test_basic();
    test_hold_reset();
    test_pause();
    test_restart_collision();
    test_async_reset();
    s_EN = 1'b1;
    test_replay_from_done();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sample_player.md
Name: sample_player

Overview:
- Downstream consumer of the sample trigger decoder's per-sample enable/reset pair. One instance exists per sample slot.
- On a restart request it streams one stored sample from a synchronous ROM at a fixed audio rate.
- Output is one sample word per audio tick, plus status flags, for the audio mixer/codec stage.

Parameters:
- ADDR_W, 14, ROM address width.
- DATA_W, 8, sample word width (two's complement).
- SAMPLE_LEN, 12000, number of ROM words in the sample. Legal range 1..2^ADDR_W.
- CLK_DIV, 6250, clock cycles per audio tick (50 MHz / 8 kHz). Must be >= 3.

Ports:
- clock, input, 1, system clock; all state is rising-edge.
- resetn, input, 1, asynchronous active-low reset.
- s_EN, input, 1, playback enable (level). Low = pause.
- s_reset, input, 1, restart request. Only a rising edge is acted on.
- rom_data, input, DATA_W, ROM read data. ROM has 1-cycle synchronous read latency.
- rom_addr, output, ADDR_W, ROM read address (registered).
- sample_out, output, DATA_W, current audio sample (registered, held between ticks).
- sample_valid, output, 1, one-cycle pulse when sample_out is updated.
- playing, output, 1, high in PLAY and DRAIN.
- done, output, 1, high in DONE.

Behaviour:
- Single clock and single reset: asynchronous active-low resetn, clock port named clock.
- Reset values:
  - state = IDLE.
  - rom_addr, sample_out, divider count and s_reset history register all 0.
  - sample_valid, playing and done all 0.
- Restart edge detection:
  - restart = s_reset & ~s_reset_q, where s_reset_q is s_reset registered.
  - Holding s_reset high produces a single restart only.
- States: IDLE, PLAY, DRAIN, DONE.
- Restart, accepted in any state:
  - next state = PLAY, rom_addr = 0, divider = 0, sample_out = 0, sample_valid = 0.
  - Restart has priority over a tick in the same cycle.
- Divider:
  - Counts 0..CLK_DIV-1 only while (PLAY & s_EN) or DRAIN. Holds its value otherwise.
  - tick = 1 when count == CLK_DIV-1; the count then wraps to 0.
- PLAY, on a tick:
  - sample_out <= rom_data and sample_valid <= 1 on that edge.
  - rom_data here is the word at rom_addr; the address has been stable for at least 2 cycles.
  - If rom_addr == SAMPLE_LEN-1: next state = DRAIN and rom_addr holds.
  - Otherwise rom_addr <= rom_addr + 1.
- PLAY, s_EN low: divider, rom_addr and sample_out all hold, so playback resumes exactly where it paused.
- DRAIN:
  - The last sample is held for one full tick period.
  - On the next tick: sample_out <= 0, sample_valid <= 1, next state = DONE.
  - s_EN is ignored in DRAIN.
- DONE: sample_out = 0, done = 1, divider idle. Leaves only on a restart.
- IDLE: outputs 0. Leaves only on a restart.
- First sample latency: first sample_valid pulse occurs CLK_DIV cycles after the restart edge, provided s_EN stays high.
- Address wrap: rom_addr never exceeds SAMPLE_LEN-1. No wrap to 0 except via restart.
- Reset mid-playback: immediate return to reset values; no drain.
- SAMPLE_LEN = 1: PLAY emits word 0 on the first tick, then goes to DRAIN.

Test Plan (CLK_DIV=4, SAMPLE_LEN=5, ROM model returns 8'h10+addr with 1-cycle latency):
- Reset, then s_EN=1 and a s_reset pulse:
  - sample_valid pulses every 4 cycles starting 4 cycles after the edge.
  - sample_out sequence: 10, 11, 12, 13, 14, then 00.
  - done rises with the 00 pulse; playing is high from the restart until done.
- Hold s_reset high for 30 cycles: exactly one playback occurs; done stays high afterwards with no retrigger.
- Drop s_EN for 10 cycles after the 11 output: no sample_valid pulses during the pause; on resume the next value is 12, arriving exactly 4 cycles of enabled time after 11.
- s_reset rising edge on the same cycle as the tick that would emit 13: no 13 is emitted; rom_addr = 0 and sample_out = 0; the next output is 10, 4 cycles later.
- Assert resetn low asynchronously while rom_addr = 3: all outputs read 0 before the next clock edge; state stays IDLE after release until a restart.
- Restart issued while in DONE: sequence 10..14, 00 replays identically.
